bank_read_return: RTL and testbench

//  Read-data return path for the 4-bank dual-port memory. The address/data decode and bank enables form the request side.
//  Per port, tracks which bank each read went to, waits out the bank read latency, selects that bank's dout and returns
//  one registered word with a valid strobe. Fully pipelined: one read per port per cycle. Sits between the 4 banks and
//  the port-A/port-B user interfaces.

---
 rtl/bank_read_return.sv | 194 +++++++++++++++++++
 tb/tb_bank_read_return.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bank_read_return.sv
// -----------------------------------------------------------------------------
// bank_read_return
//
// Read-data return path for a 4-bank dual-port memory. For each port it
// remembers which bank every read request addressed. It carries that
// information through a RD_LATENCY-deep shift pipe while the bank read
// completes. It then selects that bank's dout and returns a registered word
// together with a one-cycle valid strobe. The path is fully pipelined, so each
// port can issue one read per cycle. There is no backpressure.
//
// Timing: a request sampled at clock edge t produces bank data during cycle
// t+RD_LATENCY. That data is registered at the following edge, so o_valid_x
// and o_dout_x are seen in cycle t+RD_LATENCY+1.
//
// Optional feature, controlled by the macro BANK_CONFLICT_DETECT_EN:
//   When it is defined, o_conflict pulses for one cycle after any cycle in
//   which both ports are enabled, address the same bank, and at least one of
//   them writes. o_conflict_cnt counts these events and saturates at 8'hFF.
//   When it is undefined, both ports and their logic are absent.
//
// Ports
//   i_clk, i_rst            clock (rising edge), asynchronous active-high reset
//   i_ena/i_enb             port enables
//   i_wea/i_web             write enables (a read request is en & ~we)
//   i_addra/i_addrb         request addresses; the top 2 bits select the bank
//   i_dout_a1..i_dout_a4    port-A read data from banks 1..4
//   i_dout_b1..i_dout_b4    port-B read data from banks 1..4
//   o_dout_a/o_dout_b       returned read data (held between reads)
//   o_valid_a/o_valid_b     one-cycle strobe per returned read
//   o_conflict              (macro only) registered bank-conflict pulse
//   o_conflict_cnt          (macro only) saturating conflict counter
// -----------------------------------------------------------------------------
module bank_read_return #(
  parameter int MEM_DEPTH   = 64,
  parameter int ADDRA_WIDTH = $clog2(4*MEM_DEPTH),
  parameter int ADDRB_WIDTH = ADDRA_WIDTH,
  parameter int DATAA_WIDTH = 8,
  parameter int DATAB_WIDTH = DATAA_WIDTH,
  parameter int RD_LATENCY  = 1
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_ena,
  input  logic                   i_enb,
  input  logic                   i_wea,
  input  logic                   i_web,
  input  logic [ADDRA_WIDTH-1:0] i_addra,
  input  logic [ADDRB_WIDTH-1:0] i_addrb,
  input  logic [DATAA_WIDTH-1:0] i_dout_a1,
  input  logic [DATAA_WIDTH-1:0] i_dout_a2,
  input  logic [DATAA_WIDTH-1:0] i_dout_a3,
  input  logic [DATAA_WIDTH-1:0] i_dout_a4,
  input  logic [DATAB_WIDTH-1:0] i_dout_b1,
  input  logic [DATAB_WIDTH-1:0] i_dout_b2,
  input  logic [DATAB_WIDTH-1:0] i_dout_b3,
  input  logic [DATAB_WIDTH-1:0] i_dout_b4,
  output logic [DATAA_WIDTH-1:0] o_dout_a,
  output logic [DATAB_WIDTH-1:0] o_dout_b,
  output logic                   o_valid_a,
  output logic                   o_valid_b
`ifdef BANK_CONFLICT_DETECT_EN
  ,
  output logic                   o_conflict,
  output logic [7:0]             o_conflict_cnt
`endif
);

  // Each pipe entry is {vld, sel[1:0]}.
  localparam int PIPE_W = 3;

  logic [1:0] sel_a;
  logic [1:0] sel_b;
  logic       rd_a;
  logic       rd_b;

  assign sel_a = i_addra[ADDRA_WIDTH-1 -: 2];
  assign sel_b = i_addrb[ADDRB_WIDTH-1 -: 2];
  assign rd_a  = i_ena & ~i_wea;
  assign rd_b  = i_enb & ~i_web;

  // Only the bank-select bits of the address matter on the return side.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{i_addra[ADDRA_WIDTH-3:0], i_addrb[ADDRB_WIDTH-3:0]};

  // ---------------------------------------------------------------------------
  // Request-tracking shift pipes
  // ---------------------------------------------------------------------------
  logic [PIPE_W-1:0] pipe_a_reg  [RD_LATENCY];
  logic [PIPE_W-1:0] pipe_b_reg  [RD_LATENCY];
  logic [PIPE_W-1:0] pipe_a_next [RD_LATENCY];
  logic [PIPE_W-1:0] pipe_b_next [RD_LATENCY];

  // Stage 0 loads every cycle, so writes and idle cycles enter as bubbles.
  assign pipe_a_next[0] = {rd_a, sel_a};
  assign pipe_b_next[0] = {rd_b, sel_b};

  for (genvar gi = 1; gi < RD_LATENCY; gi++) begin : g_pipe_shift
    assign pipe_a_next[gi] = pipe_a_reg[gi-1];
    assign pipe_b_next[gi] = pipe_b_reg[gi-1];
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < RD_LATENCY; i++) begin
        pipe_a_reg[i] <= '0;
        pipe_b_reg[i] <= '0;
      end
    end else begin
      pipe_a_reg <= pipe_a_next;
      pipe_b_reg <= pipe_b_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Bank select mux, driven by the last pipe stage, which lines up with the
  // bank dout of the same request.
  // ---------------------------------------------------------------------------
  logic [PIPE_W-1:0]      last_a;
  logic [PIPE_W-1:0]      last_b;
  logic [DATAA_WIDTH-1:0] bank_a [4];
  logic [DATAB_WIDTH-1:0] bank_b [4];
  logic [DATAA_WIDTH-1:0] mux_a;
  logic [DATAB_WIDTH-1:0] mux_b;

  assign last_a = pipe_a_reg[RD_LATENCY-1];
  assign last_b = pipe_b_reg[RD_LATENCY-1];

  assign bank_a[0] = i_dout_a1;
  assign bank_a[1] = i_dout_a2;
  assign bank_a[2] = i_dout_a3;
  assign bank_a[3] = i_dout_a4;
  assign bank_b[0] = i_dout_b1;
  assign bank_b[1] = i_dout_b2;
  assign bank_b[2] = i_dout_b3;
  assign bank_b[3] = i_dout_b4;

  assign mux_a = bank_a[last_a[1:0]];
  assign mux_b = bank_b[last_b[1:0]];

  // ---------------------------------------------------------------------------
  // Output registers. The data registers hold their value across bubbles.
  // ---------------------------------------------------------------------------
  logic [DATAA_WIDTH-1:0] dout_a_reg;
  logic [DATAB_WIDTH-1:0] dout_b_reg;
  logic                   valid_a_reg;
  logic                   valid_b_reg;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      dout_a_reg  <= '0;
      dout_b_reg  <= '0;
      valid_a_reg <= 1'b0;
      valid_b_reg <= 1'b0;
    end else begin
      valid_a_reg <= last_a[2];
      valid_b_reg <= last_b[2];
      if (last_a[2]) dout_a_reg <= mux_a;
      if (last_b[2]) dout_b_reg <= mux_b;
    end
  end

  assign o_dout_a  = dout_a_reg;
  assign o_dout_b  = dout_b_reg;
  assign o_valid_a = valid_a_reg;
  assign o_valid_b = valid_b_reg;

`ifdef BANK_CONFLICT_DETECT_EN
  // ---------------------------------------------------------------------------
  // Bank conflict detection. A read-read collision on the same bank is
  // harmless; only collisions that involve a write are flagged.
  // ---------------------------------------------------------------------------
  logic       conflict_hit;
  logic       conflict_reg;
  logic [7:0] conflict_cnt_reg;

  assign conflict_hit = i_ena & i_enb & (sel_a == sel_b) & (i_wea | i_web);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      conflict_reg     <= 1'b0;
      conflict_cnt_reg <= 8'h00;
    end else begin
      conflict_reg <= conflict_hit;
      if (conflict_hit && (conflict_cnt_reg != 8'hFF)) begin
        conflict_cnt_reg <= conflict_cnt_reg + 8'h01;
      end
    end
  end

  assign o_conflict     = conflict_reg;
  assign o_conflict_cnt = conflict_cnt_reg;
`endif

endmodule

// File: tb/tb_bank_read_return.sv
// -----------------------------------------------------------------------------
// tb_bank_read_return
//
// Runs two instances of bank_read_return, with RD_LATENCY=1 and RD_LATENCY=3,
// from shared request stimulus.
//
// A simple bank RAM model supplies the bank-side dout values. It reads each
// bank at the request address after the appropriate latency.
//
// A reference model checks both instances on every falling edge. It states
// the expected behaviour directly: the output at edge k equals the read issued
// at edge k-L, looked up in the memory image. If the slot at k-L held no read,
// the output data holds its previous value.
//
// Directed sequences also compare the outputs against hand-computed literal
// values.
// -----------------------------------------------------------------------------
module tb_bank_read_return;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       ena, enb, wea, web;
  logic [7:0] addra, addrb;

  // Memory image: [port][bank][offset]
  logic [7:0] mem   [2][4][64];
  // Address history used by the bank RAM model: [port][age]
  logic [7:0] apipe [2][4];
  // Bank dout values: [instance][port][bank]
  logic [7:0] bdout [2][2][4];

  logic [7:0] d1a, d1b, d3a, d3b;
  logic       v1a, v1b, v3a, v3b;
`ifdef BANK_CONFLICT_DETECT_EN
  logic       oc1, oc3;
  logic [7:0] cnt1, cnt3;
`endif

  int checks = 0;
  int passes = 0;

  function automatic int lat(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  // ---------------------------------------------------------------------------
  // Bank RAM model: the address registered at edge t produces data L-1 edges
  // later.
  // ---------------------------------------------------------------------------
  always @(posedge clk) begin
    apipe[0][0] <= addra;
    apipe[1][0] <= addrb;
    for (int j = 1; j < 4; j++) begin
      apipe[0][j] <= apipe[0][j-1];
      apipe[1][j] <= apipe[1][j-1];
    end
  end

  always_comb begin
    for (int i = 0; i < 2; i++)
      for (int p = 0; p < 2; p++)
        for (int n = 0; n < 4; n++)
          bdout[i][p][n] = mem[p][n][apipe[p][lat(i)-1][5:0]];
  end

  // ---------------------------------------------------------------------------
  // DUT instances
  // ---------------------------------------------------------------------------
  bank_read_return #(.MEM_DEPTH(64), .DATAA_WIDTH(8), .RD_LATENCY(1)) dut1 (
    .i_clk(clk), .i_rst(rst),
    .i_ena(ena), .i_enb(enb), .i_wea(wea), .i_web(web),
    .i_addra(addra), .i_addrb(addrb),
    .i_dout_a1(bdout[0][0][0]), .i_dout_a2(bdout[0][0][1]),
    .i_dout_a3(bdout[0][0][2]), .i_dout_a4(bdout[0][0][3]),
    .i_dout_b1(bdout[0][1][0]), .i_dout_b2(bdout[0][1][1]),
    .i_dout_b3(bdout[0][1][2]), .i_dout_b4(bdout[0][1][3]),
    .o_dout_a(d1a), .o_dout_b(d1b), .o_valid_a(v1a), .o_valid_b(v1b)
`ifdef BANK_CONFLICT_DETECT_EN
    , .o_conflict(oc1), .o_conflict_cnt(cnt1)
`endif
  );

  bank_read_return #(.MEM_DEPTH(64), .DATAA_WIDTH(8), .RD_LATENCY(3)) dut3 (
    .i_clk(clk), .i_rst(rst),
    .i_ena(ena), .i_enb(enb), .i_wea(wea), .i_web(web),
    .i_addra(addra), .i_addrb(addrb),
    .i_dout_a1(bdout[1][0][0]), .i_dout_a2(bdout[1][0][1]),
    .i_dout_a3(bdout[1][0][2]), .i_dout_a4(bdout[1][0][3]),
    .i_dout_b1(bdout[1][1][0]), .i_dout_b2(bdout[1][1][1]),
    .i_dout_b3(bdout[1][1][2]), .i_dout_b4(bdout[1][1][3]),
    .o_dout_a(d3a), .o_dout_b(d3b), .o_valid_a(v3a), .o_valid_b(v3b)
`ifdef BANK_CONFLICT_DETECT_EN
    , .o_conflict(oc3), .o_conflict_cnt(cnt3)
`endif
  );

  // ---------------------------------------------------------------------------
  // Check helpers
  // ---------------------------------------------------------------------------
  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
  endtask

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: [instance][port], history ring of 8 request slots
  // ---------------------------------------------------------------------------
  logic       hv [2][2][8];
  logic [7:0] hd [2][2][8];
  logic       ev [2][2];
  logic [7:0] ed [2][2];
  logic       ec;
  logic [7:0] ecnt;
  int         cyc;

  task automatic model_clear();
    for (int i = 0; i < 2; i++)
      for (int p = 0; p < 2; p++) begin
        ev[i][p] = 1'b0;
        ed[i][p] = 8'h00;
        for (int s = 0; s < 8; s++) begin
          hv[i][p][s] = 1'b0;
          hd[i][p][s] = 8'h00;
        end
      end
    ec   = 1'b0;
    ecnt = 8'h00;
  endtask

  initial begin
    model_clear();
    cyc = 0;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        model_clear();
      end else begin
        // What each output must show after this edge: the read issued L edges ago.
        for (int i = 0; i < 2; i++)
          for (int p = 0; p < 2; p++) begin
            ev[i][p] = hv[i][p][(cyc - lat(i)) & 7];
            if (hv[i][p][(cyc - lat(i)) & 7]) ed[i][p] = hd[i][p][(cyc - lat(i)) & 7];
          end
        // Record this edge's requests.
        for (int i = 0; i < 2; i++) begin
          hv[i][0][cyc & 7] = ena && !wea;
          hd[i][0][cyc & 7] = mem[0][addra[7:6]][addra[5:0]];
          hv[i][1][cyc & 7] = enb && !web;
          hd[i][1][cyc & 7] = mem[1][addrb[7:6]][addrb[5:0]];
        end
        ec = ena && enb && (addra[7:6] == addrb[7:6]) && (wea || web);
        if (ec && ecnt != 8'hFF) ecnt = ecnt + 8'h01;
        cyc++;
      end
    end
  end

  // Compare process: every falling edge, both instances, both ports.
  initial begin
    forever begin
      @(negedge clk);
      check1("model_valid_a_L1", v1a, ev[0][0]);
      check8("model_dout_a_L1",  d1a, ed[0][0]);
      check1("model_valid_b_L1", v1b, ev[0][1]);
      check8("model_dout_b_L1",  d1b, ed[0][1]);
      check1("model_valid_a_L3", v3a, ev[1][0]);
      check8("model_dout_a_L3",  d3a, ed[1][0]);
      check1("model_valid_b_L3", v3b, ev[1][1]);
      check8("model_dout_b_L3",  d3b, ed[1][1]);
`ifdef BANK_CONFLICT_DETECT_EN
      check1("model_conflict_L1", oc1, ec);
      check8("model_cnt_L1",      cnt1, ecnt);
      check1("model_conflict_L3", oc3, ec);
      check8("model_cnt_L3",      cnt3, ecnt);
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Directed stimulus
  // ---------------------------------------------------------------------------
  task automatic idle(input int n);
    ena = 1'b0; enb = 1'b0; wea = 1'b0; web = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  logic [7:0] t2_exp [4];
  logic       t3_v   [3];
  logic [7:0] t3_d   [3];

  initial begin
    rst = 1'b0; ena = 1'b0; enb = 1'b0; wea = 1'b0; web = 1'b0;
    addra = 8'h00; addrb = 8'h00;
    for (int p = 0; p < 2; p++)
      for (int n = 0; n < 4; n++)
        for (int o = 0; o < 64; o++)
          mem[p][n][o] = 8'($urandom);
    mem[0][3][5]  = 8'h3C;   // A: 8'hC5
    mem[0][0][0]  = 8'h11;   // A: 8'h00
    mem[0][1][0]  = 8'h22;   // A: 8'h40
    mem[0][2][0]  = 8'h33;   // A: 8'h80
    mem[0][3][0]  = 8'h44;   // A: 8'hC0
    mem[0][0][16] = 8'hAA;   // A: 8'h10
    mem[0][0][18] = 8'hBB;   // A: 8'h12
    mem[0][0][5]  = 8'h5A;   // A: 8'h05
    mem[1][1][5]  = 8'hB5;   // B: 8'h45

    #2 rst = 1'b1;
    #1;
    check1("reset_valid_a", v1a, 1'b0);
    check8("reset_dout_a",  d1a, 8'h00);
    check1("reset_valid_b", v3b, 1'b0);
    check8("reset_dout_b",  d3b, 8'h00);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    idle(2);

    // 1. Single read of 8'hC5 (bank 4)
    $display("txn single read A 8'hC5");
    ena = 1'b1; wea = 1'b0; addra = 8'hC5;
    @(negedge clk); ena = 1'b0;
    check1("t1_valid_early", v1a, 1'b0);
    @(negedge clk);
    check1("t1_valid", v1a, 1'b1);
    check8("t1_data",  d1a, 8'h3C);
    @(negedge clk);
    check1("t1_valid_off", v1a, 1'b0);
    check8("t1_hold",      d1a, 8'h3C);
    idle(4);

    // 2. Streaming reads across all four banks
    $display("txn streaming A 00/40/80/C0");
    t2_exp[0] = 8'h11; t2_exp[1] = 8'h22; t2_exp[2] = 8'h33; t2_exp[3] = 8'h44;
    for (int k = 0; k < 6; k++) begin
      if (k >= 2) begin
        check1("t2_valid", v1a, 1'b1);
        check8("t2_data",  d1a, t2_exp[k-2]);
      end
      if (k < 4) begin
        ena = 1'b1; wea = 1'b0; addra = 8'(k << 6);
      end else begin
        ena = 1'b0;
      end
      @(negedge clk);
    end
    check1("t2_valid_end", v1a, 1'b0);
    idle(4);

    // 3. Write bubble between two reads
    $display("txn read 10 / write 11 / read 12 on A");
    t3_v[0] = 1'b1; t3_v[1] = 1'b0; t3_v[2] = 1'b1;
    t3_d[0] = 8'hAA; t3_d[1] = 8'hAA; t3_d[2] = 8'hBB;
    for (int k = 0; k < 5; k++) begin
      if (k >= 2) begin
        check1("t3_valid", v1a, t3_v[k-2]);
        check8("t3_data",  d1a, t3_d[k-2]);
      end
      if (k < 3) begin
        ena = 1'b1; wea = (k == 1); addra = 8'(8'h10 + k);
      end else begin
        ena = 1'b0; wea = 1'b0;
      end
      @(negedge clk);
    end
    idle(4);

    // 4. Both ports read in the same cycle, checked at both latencies
    $display("txn dual read A 05 / B 45");
    ena = 1'b1; wea = 1'b0; addra = 8'h05;
    enb = 1'b1; web = 1'b0; addrb = 8'h45;
    @(negedge clk); ena = 1'b0; enb = 1'b0;
    @(negedge clk);
    check1("t4_va_L1", v1a, 1'b1);
    check1("t4_vb_L1", v1b, 1'b1);
    check8("t4_da_L1", d1a, 8'h5A);
    check8("t4_db_L1", d1b, 8'hB5);
    check1("t4_va_L3_early", v3a, 1'b0);
    @(negedge clk);
    @(negedge clk);
    check1("t4_va_L3", v3a, 1'b1);
    check1("t4_vb_L3", v3b, 1'b1);
    check8("t4_da_L3", d3a, 8'h5A);
    check8("t4_db_L3", d3b, 8'hB5);
    idle(4);

    // 5. Asynchronous reset while a read is in flight
    $display("txn reset mid-flight");
    ena = 1'b1; wea = 1'b0; addra = 8'hC5;
    @(negedge clk); ena = 1'b0;
    #2 rst = 1'b1;
    #1;
    check8("t5_dout_a_async", d1a, 8'h00);
    check8("t5_dout_b_async", d1b, 8'h00);
    check8("t5_dout_a_L3",    d3a, 8'h00);
    #1 rst = 1'b0;
    @(negedge clk);
    check1("t5_no_valid", v1a, 1'b0);
    idle(4);

`ifdef BANK_CONFLICT_DETECT_EN
    // 6. Bank conflict pulse and saturating counter
    $display("txn conflict A write 83 / B read 9F");
    ena = 1'b1; wea = 1'b1; addra = 8'h83;
    enb = 1'b1; web = 1'b0; addrb = 8'h9F;
    @(negedge clk);
    wea = 1'b0; addrb = 8'h83;
    check1("t6_conflict", oc1, 1'b1);
    check8("t6_cnt",      cnt1, 8'h01);
    @(negedge clk);
    check1("t6_rr_no_conflict", oc1, 1'b0);
    check8("t6_cnt_hold",       cnt1, 8'h01);
    $display("txn 300 conflicts");
    wea = 1'b1; addrb = 8'h9F;
    repeat (300) @(negedge clk);
    check8("t6_cnt_sat", cnt1, 8'hFF);
    idle(4);
`endif

    // Mixed traffic on both ports, checked by the model only
    $display("txn mixed traffic");
    for (int k = 0; k < 80; k++) begin
      ena = 1'($urandom); enb = 1'($urandom);
      wea = ($urandom_range(0, 3) == 0); web = ($urandom_range(0, 3) == 0);
      addra = 8'($urandom); addrb = 8'($urandom);
      @(negedge clk);
    end
    idle(6);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
